i2c_master_burst: RTL and testbench

Parametrised successor to the single-byte i2c_master. It performs multi-byte I2C write or read bursts to a 7-bit device address, with a configurable SCL divider, slave-ACK checking and master ACK/NACK generation on reads. It sits between game/display control logic and the external I2C bus; it drives open-drain SDA/SCL at the pads.

---
 rtl/i2c_pkg.sv | 25 ++
 rtl/i2c_master_burst_timer.sv | 34 +++
 rtl/i2c_master_burst.sv | 185 ++++++++++++++++++
 tb/tb_i2c_master_burst.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared types and constants for the burst I2C master.
// State encoding, quarter-phase names and ACK levels.
package i2c_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_START,
    S_ADDR,
    S_AACK,
    S_WDATA,
    S_WACK,
    S_RDATA,
    S_MACK,
    S_STOP
  } state_t;

  localparam logic [1:0] Q0 = 2'd0;
  localparam logic [1:0] Q1 = 2'd1;
  localparam logic [1:0] Q2 = 2'd2;
  localparam logic [1:0] Q3 = 2'd3;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

endpackage

// File: rtl/i2c_master_burst_timer.sv
// Quarter-bit divider: qtick marks the last clk of each quarter,
// phase names the quarter currently running.
module i2c_bit_timer
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic       qtick,
  output logic [1:0] phase
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  assign qtick = en && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      cnt   <= '0;
      phase <= Q0;
    end else if (qtick) begin
      cnt   <= '0;
      phase <= phase + 2'd1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/i2c_master_burst.sv
// Multi-byte I2C master: write or read bursts to a 7-bit address,
// open-drain pads, slave ACK checking and master ACK/NACK on reads.
module i2c_master_burst
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int MAX_LEN = 16,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             rw,
  input  logic [6:0]       dev_addr,
  input  logic [LEN_W-1:0] len,
  input  logic [7:0]       wr_data,
  output logic             wr_next,
  output logic [7:0]       rd_data,
  output logic             rd_valid,
  output logic             busy,
  output logic             done,
  output logic             nack,
  inout  wire              sda,
  output logic             scl
);

  state_t           state;
  logic             qtick;
  logic [1:0]       phase;
  logic             sda_oe;
  logic             scl_oe;
  logic [7:0]       sh;
  logic [2:0]       bit_cnt;
  logic [LEN_W-1:0] rem;
  logic [LEN_W-1:0] len_c;
  logic             rw_q;
  logic             ack_bit;
  logic             err;
  logic             end_ack;

  i2c_bit_timer #(.CLK_DIV(CLK_DIV)) u_timer (
    .clk   (clk),
    .rst   (rst),
    .en    (state != S_IDLE),
    .qtick (qtick),
    .phase (phase)
  );

  assign sda = sda_oe ? 1'b0 : 1'bz;
  assign scl = scl_oe ? 1'b0 : 1'bz;

  assign len_c = (len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : len;

  assign end_ack = qtick && (phase == Q3) &&
                   (state == S_AACK || state == S_WACK);

  // Combinational so the byte is taken in the last cycle of the ACK bit
  assign wr_next = end_ack && !rw_q &&
                   (ack_bit == I2C_ACK) && (rem != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      sda_oe   <= 1'b0;
      scl_oe   <= 1'b0;
      sh       <= 8'h00;
      bit_cnt  <= 3'd0;
      rem      <= '0;
      rw_q     <= 1'b0;
      ack_bit  <= I2C_NACK;
      err      <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      nack     <= 1'b0;
      rd_data  <= 8'h00;
      rd_valid <= 1'b0;
    end else begin
      done     <= 1'b0;
      rd_valid <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start && !done) begin
            state   <= S_START;
            busy    <= 1'b1;
            nack    <= 1'b0;
            err     <= 1'b0;
            rw_q    <= rw;
            sh      <= {dev_addr, rw};
            rem     <= len_c;
            bit_cnt <= 3'd0;
            sda_oe  <= 1'b1;
          end
        end
        S_START: begin
          if (qtick && phase == Q1) scl_oe <= 1'b1;
          if (qtick && phase == Q3) begin
            state  <= S_ADDR;
            sda_oe <= ~sh[7];
          end
        end
        S_STOP: begin
          if (qtick && phase == Q0) scl_oe <= 1'b0;
          if (qtick && phase == Q2) sda_oe <= 1'b0;
          if (qtick && phase == Q3) begin
            state <= S_IDLE;
            done  <= 1'b1;
            busy  <= 1'b0;
            nack  <= err;
          end
        end
        default: begin
          if (qtick) begin
            unique case (phase)
              Q0: scl_oe <= 1'b0;
              Q1: begin
                ack_bit <= sda;
                if (state == S_RDATA) begin
                  sh <= {sh[6:0], sda};
                  if (bit_cnt == 3'd7) begin
                    rd_data  <= {sh[6:0], sda};
                    rd_valid <= 1'b1;
                  end
                end
              end
              Q2: scl_oe <= 1'b1;
              Q3: begin
                unique case (state)
                  S_ADDR, S_WDATA: begin
                    if (bit_cnt == 3'd7) begin
                      state   <= (state == S_ADDR) ? S_AACK : S_WACK;
                      sda_oe  <= 1'b0;
                      bit_cnt <= 3'd0;
                    end else begin
                      bit_cnt <= bit_cnt + 3'd1;
                      sh      <= {sh[6:0], 1'b0};
                      sda_oe  <= ~sh[6];
                    end
                  end
                  S_AACK, S_WACK: begin
                    if (ack_bit == I2C_NACK || rem == '0) begin
                      err    <= (ack_bit == I2C_NACK);
                      state  <= S_STOP;
                      sda_oe <= 1'b1;
                    end else if (!rw_q) begin
                      state  <= S_WDATA;
                      rem    <= rem - LEN_W'(1);
                      sh     <= wr_data;
                      sda_oe <= ~wr_data[7];
                    end else begin
                      state  <= S_RDATA;
                      rem    <= rem - LEN_W'(1);
                      sda_oe <= 1'b0;
                    end
                  end
                  S_RDATA: begin
                    if (bit_cnt == 3'd7) begin
                      state   <= S_MACK;
                      bit_cnt <= 3'd0;
                      sda_oe  <= (rem != '0);
                    end else begin
                      bit_cnt <= bit_cnt + 3'd1;
                    end
                  end
                  S_MACK: begin
                    if (rem == '0) begin
                      state  <= S_STOP;
                      sda_oe <= 1'b1;
                    end else begin
                      state  <= S_RDATA;
                      rem    <= rem - LEN_W'(1);
                      sda_oe <= 1'b0;
                    end
                  end
                  default: ;
                endcase
              end
              default: ;
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_master_burst.sv
// Bench for i2c_master_burst: behavioural slave + bus decoder,
// directed and random bursts checked against a transaction model.
module tb_i2c_master_burst;

  localparam int CLK_DIV = 2;
  localparam int MAX_LEN = 16;
  localparam int LEN_W   = 5;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             rw = 1'b0;
  logic [6:0]       dev_addr = 7'h00;
  logic [LEN_W-1:0] len = '0;
  logic [7:0]       wr_data;
  logic             wr_next, rd_valid, busy, done, nack;
  logic [7:0]       rd_data;
  wire              sda, scl;
  logic             sdrv = 1'b0;

  pullup (sda);
  pullup (scl);
  assign sda = sdrv ? 1'b0 : 1'bz;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  i2c_master_burst #(.CLK_DIV(CLK_DIV), .MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .start(start), .rw(rw), .dev_addr(dev_addr),
    .len(len), .wr_data(wr_data), .wr_next(wr_next), .rd_data(rd_data),
    .rd_valid(rd_valid), .busy(busy), .done(done), .nack(nack),
    .sda(sda), .scl(scl)
  );

  logic [7:0] wbuf [0:31];
  logic [7:0] rbuf [0:31];
  int         nack_frame = -1;
  int         wbase = 0;

  // Slave + bus decoder: sole owner of the bus-side records
  logic [7:0] bus_q [$];
  logic       ack_q [$];
  int         starts = 0, stops = 0, pulses = 0, bitn = 0, frame = 0;
  logic       got = 1'b0, is_read = 1'b0, active = 1'b0;
  logic [7:0] sh = 8'h00;
  logic       ps = 1'b1, pd = 1'b1;

  always @(scl, sda) begin
    if (scl !== ps) begin
      if (scl === 1'b1) begin
        got = 1'b1;
        if (bitn < 8) begin
          sh = {sh[6:0], sda};
          if (bitn == 7) begin
            bus_q.push_back(sh);
            if (frame == 0) is_read = sda;
          end
        end else begin
          ack_q.push_back(sda);
          if (sda === 1'b1 && (frame == 0 || is_read)) active = 1'b0;
        end
      end else if (got) begin
        got = 1'b0;
        pulses++;
        bitn++;
        if (bitn == 9) begin
          bitn = 0;
          frame++;
        end
        sdrv = 1'b0;
        if (active) begin
          if (bitn == 8)
            sdrv = (frame == 0 || !is_read) && (frame != nack_frame);
          else if (is_read && frame > 0)
            sdrv = !rbuf[(frame - 1) & 31][7 - bitn];
        end
      end
    end else if (scl === 1'b1 && sda !== pd) begin
      if (sda === 1'b0) begin
        starts++;
        bitn = 0; frame = 0; got = 1'b0; active = 1'b1; sdrv = 1'b0;
      end else begin
        stops++;
        sdrv = 1'b0;
      end
    end
    ps = scl;
    pd = sda;
  end

  // Host-side records and write-data supply
  int         wr_cnt = 0, done_cnt = 0;
  logic [7:0] rdv_q [$];

  always @(negedge clk) begin
    wr_data = wbuf[(wr_cnt - wbase) & 31];
    if (wr_next) wr_cnt++;
    if (rd_valid) rdv_q.push_back(rd_data);
    if (done) done_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got_v,
                     input logic [31:0] exp_v);
    checks++;
    assert (got_v === exp_v) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got_v, exp_v);
    end
  endtask

  task automatic xfer(input logic r, input logic [6:0] a, input int l,
                      input int nf, input bit poke);
    int n, k, cyc;
    int b_st, b_sp, b_pu, b_wr, b_dn, b_bus, b_ack, b_rdv;
    logic exp_nack;
    n = (l > MAX_LEN) ? MAX_LEN : l;
    if (nf == 0) k = 0;
    else if (!r && nf >= 1 && nf <= n) k = nf;
    else k = n;
    exp_nack = (nf == 0) || (!r && nf >= 1 && nf <= n);
    nack_frame = nf;
    b_st = starts; b_sp = stops; b_pu = pulses; b_wr = wr_cnt;
    b_dn = done_cnt; b_bus = bus_q.size(); b_ack = ack_q.size();
    b_rdv = rdv_q.size();
    wbase = wr_cnt;
    @(negedge clk);
    start = 1'b1; rw = r; dev_addr = a; len = LEN_W'(l);
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    cyc = 0;
    while (done !== 1'b1 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (poke && cyc == 40) begin
        start = 1'b1; rw = ~r; dev_addr = ~a; len = LEN_W'(1);
      end else begin
        start = 1'b0;
      end
    end
    chk("done_seen", done, 1);
    chk("nack_at_done", nack, exp_nack);
    chk("busy_at_done", busy, 0);
    if (poke) start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("busy_after", busy, 0);
    chk("nack_held", nack, exp_nack);
    chk("starts", starts - b_st, 1);
    chk("stops", stops - b_sp, 1);
    chk("scl_pulses", pulses - b_pu, 9 * (1 + k));
    chk("wr_next_cnt", wr_cnt - b_wr, r ? 0 : k);
    chk("done_cnt", done_cnt - b_dn, 1);
    chk("bus_bytes", bus_q.size() - b_bus, 1 + k);
    chk("ack_bits", ack_q.size() - b_ack, 1 + k);
    chk("rd_valid_cnt", rdv_q.size() - b_rdv, r ? k : 0);
    if (bus_q.size() - b_bus == 1 + k && ack_q.size() - b_ack == 1 + k) begin
      chk("addr_byte", bus_q[b_bus], {a, r});
      chk("addr_ack", ack_q[b_ack], nf == 0);
      for (int j = 1; j <= k; j++) begin
        chk("data_byte", bus_q[b_bus + j], r ? rbuf[j - 1] : wbuf[j - 1]);
        chk("data_ack", ack_q[b_ack + j], r ? (j == k) : (j == nf));
      end
    end
    if (r && rdv_q.size() - b_rdv == k) begin
      for (int j = 0; j < k; j++)
        chk("rd_data", rdv_q[b_rdv + j], rbuf[j]);
      if (k > 0) chk("rd_data_hold", rd_data, rbuf[k - 1]);
    end
  endtask

  initial begin
    int b_dn, b_wr, cyc, l, nf;
    logic r;
    for (int i = 0; i < 32; i++) begin
      wbuf[i] = 8'($urandom);
      rbuf[i] = 8'($urandom);
    end
    repeat (4) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_nack", nack, 0);
    chk("rst_wr_next", wr_next, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 8'h00);
    chk("rst_sda", sda, 1);
    chk("rst_scl", scl, 1);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    wbuf[0] = 8'hAA; wbuf[1] = 8'h55;
    xfer(1'b0, 7'h50, 2, -1, 1'b0);
    rbuf[0] = 8'h12; rbuf[1] = 8'h34; rbuf[2] = 8'h56;
    xfer(1'b1, 7'h50, 3, -1, 1'b0);
    xfer(1'b0, 7'h50, 3, 0, 1'b0);
    xfer(1'b0, 7'h3C, 0, -1, 1'b0);
    xfer(1'b0, 7'h21, 4, 2, 1'b0);
    xfer(1'b0, 7'h11, 2, -1, 1'b1);
    for (int i = 0; i < 32; i++) wbuf[i] = 8'($urandom);
    xfer(1'b0, 7'h44, 20, -1, 1'b0);

    b_dn = done_cnt; b_wr = wr_cnt; wbase = wr_cnt; nack_frame = -1;
    @(negedge clk);
    start = 1'b1; rw = 1'b0; dev_addr = 7'h2A; len = LEN_W'(4);
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (wr_cnt - b_wr < 2 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    chk("second_byte_reached", cyc < 2000, 1);
    repeat (24) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_sda", sda, 1);
    chk("midrst_scl", scl, 1);
    chk("midrst_busy", busy, 0);
    repeat (100) @(negedge clk);
    chk("midrst_no_done", done_cnt - b_dn, 0);
    xfer(1'b0, 7'h2A, 4, -1, 1'b0);

    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < 32; i++) begin
        wbuf[i] = 8'($urandom);
        rbuf[i] = 8'($urandom);
      end
      r = 1'($urandom);
      l = int'($urandom_range(0, 18));
      nf = -1;
      if ($urandom_range(0, 3) == 0) nf = 0;
      else if (!r && l > 0 && $urandom_range(0, 2) == 0)
        nf = int'($urandom_range(1, l > MAX_LEN ? MAX_LEN : l));
      xfer(r, 7'($urandom), l, nf, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
